// File: rtl/mac_pkg.sv
// Shared MAC-array types: accumulator width and the ping-pong bank state encoding.
package mac_pkg;

   localparam int ACC_W = 32;

   typedef enum logic [1:0] {
      BANK_EMPTY,
      BANK_FILLING,
      BANK_FULL,
      BANK_DRAINING
   } bank_state_t;

endpackage : mac_pkg

// File: rtl/ofmap_drain_buffer_if.sv
// Row capture and drain stream bundle for ofmap_drain_buffer; master is the
// array/writer side, slave is the buffer.
interface ofmap_drain_buffer_if
   import mac_pkg::*;
#(
   parameter int OC0 = 4
);
   logic                 en;
   logic                 in_valid;
   logic [ACC_W*OC0-1:0] in_dat;
   logic                 flush;
   logic                 out_valid;
   logic                 out_ready;
   logic [ACC_W*OC0-1:0] out_dat;
   logic                 out_last;
   logic                 out_bank;
   logic                 overflow;

   modport master (
      output en, in_valid, in_dat, flush, out_ready,
      input  out_valid, out_dat, out_last, out_bank, overflow
   );

   modport slave (
      input  en, in_valid, in_dat, flush, out_ready,
      output out_valid, out_dat, out_last, out_bank, overflow
   );

endinterface : ofmap_drain_buffer_if

// File: rtl/ofmap_bank.sv
// One half of the ofmap ping-pong buffer: DEPTH-row flop storage, bank FSM,
// write count, latched fill count and read pointer.
module ofmap_bank
   import mac_pkg::*;
#(
   parameter int OC0   = 4,
   parameter int DEPTH = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 wr,
   input  logic [ACC_W*OC0-1:0] wr_dat,
   input  logic                 flush,
   input  logic                 load,
   input  logic                 free,
   output bank_state_t          state,
   output logic                 closing,
   output logic                 can_load,
   output logic [ACC_W*OC0-1:0] rd_dat,
   output logic                 rd_last
);

   localparam int          AW       = $clog2(DEPTH);
   localparam logic [AW:0] LAST_IDX = (AW+1)'(DEPTH - 1);
   localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);

   bank_state_t          state_q, state_d;
   logic [AW:0]          wr_cnt_q, wr_cnt_d;
   logic [AW:0]          fill_q, fill_d;
   logic [AW:0]          rd_ptr_q, rd_ptr_d;
   logic [ACC_W*OC0-1:0] mem [DEPTH];
   logic                 open;
   logic                 wr_full;

   assign open    = (state_q == BANK_EMPTY) || (state_q == BANK_FILLING);
   assign wr_full = wr && (wr_cnt_q == LAST_IDX);
   assign closing = open && (wr_full || (flush && state_q == BANK_FILLING));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= BANK_EMPTY;
         wr_cnt_q <= '0;
         fill_q   <= '0;
         rd_ptr_q <= '0;
      end else begin
         // NOTE: non-blocking so every register here samples pre-edge values.
         state_q  <= state_d;
         wr_cnt_q <= wr_cnt_d;
         fill_q   <= fill_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // NOTE: row storage has no reset; the FSM and counters decide what is valid.
   always_ff @(posedge clk) begin
      if (wr) mem[wr_cnt_q[AW-1:0]] <= wr_dat;
   end

   always_comb begin
      // NOTE: defaults first so no path through the case infers a latch.
      state_d  = state_q;
      wr_cnt_d = wr_cnt_q;
      fill_d   = fill_q;
      rd_ptr_d = rd_ptr_q;
      unique case (state_q)
         BANK_EMPTY, BANK_FILLING: begin
            if (wr) begin
               wr_cnt_d = wr_cnt_q + CNT_ONE;
               state_d  = BANK_FILLING;
            end
            // A row arriving with the flush is counted before the bank closes.
            if (closing) begin
               state_d  = BANK_FULL;
               fill_d   = wr_cnt_q + {{AW{1'b0}}, wr};
               wr_cnt_d = '0;
            end
         end
         BANK_FULL: begin
            if (load) begin
               state_d  = BANK_DRAINING;
               rd_ptr_d = CNT_ONE;
            end
         end
         BANK_DRAINING: begin
            if (load) rd_ptr_d = rd_ptr_q + CNT_ONE;
            if (free) begin
               state_d  = BANK_EMPTY;
               rd_ptr_d = '0;
               fill_d   = '0;
            end
         end
         default: state_d = BANK_EMPTY;
      endcase
   end

   always_comb begin
      state    = state_q;
      can_load = (state_q == BANK_FULL) ||
                 ((state_q == BANK_DRAINING) && (rd_ptr_q < fill_q));
      rd_dat   = mem[rd_ptr_q[AW-1:0]];
      rd_last  = (rd_ptr_q == fill_q - CNT_ONE);
   end

endmodule : ofmap_bank

// File: rtl/ofmap_drain_buffer.sv
// Ping-pong ofmap drain buffer: two ofmap_bank halves, write/read bank select,
// sticky overflow and a registered valid/ready output stage.
// Optional macro OFMAP_RELU_EN clamps each lane to max(lane,0) on output load.
module ofmap_drain_buffer
   import mac_pkg::*;
#(
   parameter int OC0   = 4,
   parameter int DEPTH = 16
) (
   input logic                 clk,
   input logic                 rst_n,
   ofmap_drain_buffer_if.slave bus
);

   localparam int RW = ACC_W * OC0;

   logic          wsel_q, wsel_d, rsel_q;
   logic          overflow_q;
   logic          out_valid_q, out_last_q, out_bank_q;
   logic [RW-1:0] out_dat_q;

   bank_state_t   st       [2];
   logic          wr       [2];
   logic          flush_b  [2];
   logic          load     [2];
   logic          free     [2];
   logic          closing  [2];
   logic          can_load [2];
   logic          rd_last  [2];
   logic [RW-1:0] rd_dat   [2];

   logic          w, w_open, take, fire_last, wbank_closed, peer_avail;
   logic [RW-1:0] load_row;

   assign w         = bus.en & bus.in_valid;
   assign w_open    = (st[wsel_q] == BANK_EMPTY) || (st[wsel_q] == BANK_FILLING);
   assign take      = !out_valid_q || bus.out_ready;
   assign fire_last = out_valid_q && bus.out_ready && out_last_q;

   always_comb begin
      for (int b = 0; b < 2; b++) begin
         wr[b]      = w && w_open && (wsel_q == 1'(b));
         flush_b[b] = bus.flush && (wsel_q == 1'(b));
         load[b]    = take && can_load[rsel_q] && (rsel_q == 1'(b));
         free[b]    = fire_last && (out_bank_q == 1'(b));
      end
   end

   for (genvar g = 0; g < 2; g++) begin : g_bank
      ofmap_bank #(
         .OC0   (OC0),
         .DEPTH (DEPTH)
      ) u_bank (
         .clk      (clk),
         .rst_n    (rst_n),
         .wr       (wr[g]),
         .wr_dat   (bus.in_dat),
         .flush    (flush_b[g]),
         .load     (load[g]),
         .free     (free[g]),
         .state    (st[g]),
         .closing  (closing[g]),
         .can_load (can_load[g]),
         .rd_dat   (rd_dat[g]),
         .rd_last  (rd_last[g])
      );
   end

   // Leave a closed bank as soon as its peer is empty or is being freed this edge.
   assign wbank_closed = closing[wsel_q] || (st[wsel_q] == BANK_FULL) ||
                         (st[wsel_q] == BANK_DRAINING);
   assign peer_avail   = (st[~wsel_q] == BANK_EMPTY) || free[~wsel_q];
   assign wsel_d       = (wbank_closed && peer_avail) ? ~wsel_q : wsel_q;

   always_comb begin
      load_row = rd_dat[rsel_q];
`ifdef OFMAP_RELU_EN
      for (int i = 0; i < OC0; i++) begin
         if (load_row[ACC_W*i + ACC_W-1]) load_row[ACC_W*i +: ACC_W] = '0;
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wsel_q      <= 1'b0;
         rsel_q      <= 1'b0;
         overflow_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_dat_q   <= '0;
         out_last_q  <= 1'b0;
         out_bank_q  <= 1'b0;
      end else begin
         wsel_q <= wsel_d;
         if (fire_last) rsel_q <= ~rsel_q;
         if (w && !w_open) overflow_q <= 1'b1;
         // Payload only changes on a load, so it holds while stalled.
         if (take) begin
            if (can_load[rsel_q]) begin
               out_valid_q <= 1'b1;
               out_dat_q   <= load_row;
               out_last_q  <= rd_last[rsel_q];
               out_bank_q  <= rsel_q;
            end else begin
               out_valid_q <= 1'b0;
            end
         end
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_dat   = out_dat_q;
   assign bus.out_last  = out_last_q;
   assign bus.out_bank  = out_bank_q;
   assign bus.overflow  = overflow_q;

endmodule : ofmap_drain_buffer
